// File: rtl/qr_frame_scheduler.sv
// qr_frame_scheduler
// Collects 4-word matrix rows into a ping-pong frame buffer and replays each
// complete frame to the QR core as one unbroken core_in_valid burst. An idle
// gap follows every burst so the core sees each frame start. Frames in flight
// are counted against a credit limit. Completions and protocol errors are
// reported back to the controller.
module qr_frame_scheduler #(
  parameter int W            = 20,
  parameter int N_ROWS       = 4,
  parameter int GAP          = 1,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         cfg_enable,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data1,
  input  logic [W-1:0] s_data2,
  input  logic [W-1:0] s_data3,
  input  logic [W-1:0] s_data4,
  input  logic         s_last,
  output logic         core_in_valid,
  output logic [W-1:0] core_data1,
  output logic [W-1:0] core_data2,
  output logic [W-1:0] core_data3,
  output logic [W-1:0] core_data4,
  input  logic         core_out_valid,
  output logic         frame_done,
  output logic [2:0]   inflight,
  output logic [15:0]  frames_issued,
  output logic         err_framing,
  output logic         err_unexpected
);

  localparam int RW    = $clog2(N_ROWS);
  localparam int AW    = $clog2(2 * N_ROWS);
  localparam int GW    = $clog2(GAP + 1);
  localparam int DEPTH = 2 * N_ROWS;

  localparam logic [RW-1:0] LAST_ROW   = RW'(N_ROWS - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP);
  localparam logic [2:0]    MAX_CREDIT = 3'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic [RW-1:0]    wr_row_q, wr_row_d;
  logic             rd_bank_q, rd_bank_d;
  logic [RW-1:0]    rd_row_q, rd_row_d;
  logic [1:0]       full_q, full_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [2:0]       inflight_q, inflight_d;
  logic [15:0]      issued_q, issued_d;
  logic             err_framing_q, err_framing_d;
  logic             err_unexp_q, err_unexp_d;
  logic             cov_prev_q;
  logic             civ_q, civ_d;
  logic [4*W-1:0]   cdata_q, cdata_d;
  logic             done_q, done_d;

  // Frame storage: bank 0 occupies entries 0..N_ROWS-1, bank 1 the rest
  logic [4*W-1:0]   mem_q [DEPTH];

  logic             accept_s;
  logic             wr_last_s;
  logic             rise_s;
  logic             complete_s;
  logic             launch_s;
  logic             rd_done_s;
  logic [AW-1:0]    wr_addr_s;
  logic [AW-1:0]    rd_addr_s;
  logic [4*W-1:0]   rd_data_s;

  // Upstream may only write into a bank that is not holding an unissued frame
  assign s_ready    = ~Reset & cfg_enable & ~full_q[wr_bank_q];
  assign accept_s   = s_valid & s_ready;
  assign wr_last_s  = (wr_row_q == LAST_ROW);
  assign rise_s     = core_out_valid & ~cov_prev_q;
  assign complete_s = rise_s & (inflight_q != 3'd0);
  assign wr_addr_s  = wr_bank_q ? (AW'(N_ROWS) + AW'(wr_row_q)) : AW'(wr_row_q);
  // Read address follows the next row so the output register gets it in step
  assign rd_addr_s  = rd_bank_q ? (AW'(N_ROWS) + AW'(rd_row_d)) : AW'(rd_row_d);
  assign rd_data_s  = mem_q[rd_addr_s];

  // Issue FSM next state: launch decision, row sequencing, gap countdown
  always_comb begin
    state_d   = state_q;
    rd_row_d  = rd_row_q;
    rd_bank_d = rd_bank_q;
    gap_d     = gap_q;
    launch_s  = 1'b0;
    rd_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q] && cfg_enable && (inflight_q < MAX_CREDIT)) begin
          state_d  = ST_ISSUE;
          rd_row_d = {RW{1'b0}};
          launch_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (rd_row_q == LAST_ROW) begin
          state_d   = ST_GAP;
          rd_row_d  = {RW{1'b0}};
          rd_bank_d = ~rd_bank_q;
          gap_d     = GAP_LOAD;
          rd_done_s = 1'b1;
        end else begin
          rd_row_d = rd_row_q + RW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d = ST_IDLE;
          gap_d   = {GW{1'b0}};
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rd_row_d = {RW{1'b0}};
        gap_d    = {GW{1'b0}};
      end
    endcase
  end

  // Datapath next state: write pointers, bank flags, counters, error flags, core outputs
  always_comb begin
    wr_bank_d     = wr_bank_q;
    wr_row_d      = wr_row_q;
    full_d        = full_q;
    err_framing_d = err_framing_q;
    err_unexp_d   = err_unexp_q;
    inflight_d    = inflight_q;
    issued_d      = issued_q;
    civ_d         = 1'b0;
    cdata_d       = cdata_q;
    done_d        = 1'b0;

    if (accept_s) begin
      // Framing is by row count; a misplaced s_last is only flagged
      if (s_last != wr_last_s) begin
        err_framing_d = 1'b1;
      end else begin
        err_framing_d = err_framing_q;
      end
      if (wr_last_s) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_row_d          = {RW{1'b0}};
      end else begin
        wr_row_d = wr_row_q + RW'(1);
      end
    end else begin
      wr_row_d = wr_row_q;
    end

    // The bank being read is never the bank being written, so no conflict here
    if (rd_done_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d[rd_bank_q] = full_d[rd_bank_q];
    end

    case ({launch_s, complete_s})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase

    if (launch_s) begin
      issued_d = issued_q + 16'd1;
    end else begin
      issued_d = issued_q;
    end

    if (rise_s && (inflight_q == 3'd0)) begin
      err_unexp_d = 1'b1;
    end else begin
      err_unexp_d = err_unexp_q;
    end

    done_d = complete_s;

    // Core data only moves while a burst is on the bus
    if (state_d == ST_ISSUE) begin
      civ_d   = 1'b1;
      cdata_d = rd_data_s;
    end else begin
      civ_d   = 1'b0;
      cdata_d = cdata_q;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      wr_bank_q     <= 1'b0;
      wr_row_q      <= {RW{1'b0}};
      rd_bank_q     <= 1'b0;
      rd_row_q      <= {RW{1'b0}};
      full_q        <= 2'b00;
      gap_q         <= {GW{1'b0}};
      inflight_q    <= 3'd0;
      issued_q      <= 16'd0;
      err_framing_q <= 1'b0;
      err_unexp_q   <= 1'b0;
      cov_prev_q    <= 1'b0;
      civ_q         <= 1'b0;
      cdata_q       <= {(4*W){1'b0}};
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      wr_row_q      <= wr_row_d;
      rd_bank_q     <= rd_bank_d;
      rd_row_q      <= rd_row_d;
      full_q        <= full_d;
      gap_q         <= gap_d;
      inflight_q    <= inflight_d;
      issued_q      <= issued_d;
      err_framing_q <= err_framing_d;
      err_unexp_q   <= err_unexp_d;
      cov_prev_q    <= core_out_valid;
      civ_q         <= civ_d;
      cdata_q       <= cdata_d;
      done_q        <= done_d;
    end
  end

  // Frame buffer write port; no reset needed because full_q gates every read
  always_ff @(posedge Clk) begin
    if (accept_s) begin
      mem_q[wr_addr_s] <= {s_data1, s_data2, s_data3, s_data4};
    end
  end

  assign core_in_valid  = civ_q;
  assign core_data1     = cdata_q[4*W-1:3*W];
  assign core_data2     = cdata_q[3*W-1:2*W];
  assign core_data3     = cdata_q[2*W-1:W];
  assign core_data4     = cdata_q[W-1:0];
  assign frame_done     = done_q;
  assign inflight       = inflight_q;
  assign frames_issued  = issued_q;
  assign err_framing    = err_framing_q;
  assign err_unexpected = err_unexp_q;

endmodule
